// File: rtl/assistance_pi_controller.sv
// Motor-assistance demand: PI heart-rate loop with pitch feed-forward, slew-limited ramp-up,
// brake/cadence gating and latched tilt-fault shutdown with timed recovery.
//   state  | meaning
//   IDLE   | no assistance, integrator cleared, waiting for pedalling and a valid mode
//   ASSIST | demand follows the PI or fixed-level target through the slew limiter
//   FAULT  | tilt fault latched, output forced to 0 until roll settles long enough
module assistance_pi_controller #(
   parameter int OUT_W         = 13,
   parameter int HR_W          = 8,
   parameter int ANG_W         = 10,
   parameter int KP            = 40,
   parameter int KI            = 2,
   parameter int INTEG_MAX     = 1023,
   parameter int HR_OFFSET     = 15,
   parameter int PITCH_SHIFT   = 3,
   parameter int ROLL_LIMIT    = 45,
   parameter int ROLL_RECOVER  = 20,
   parameter int RECOVER_TICKS = 8,
   parameter int SLEW_STEP     = 64,
   parameter int CAD_TIMEOUT   = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    update,
   input  logic signed [ANG_W-1:0] roll,
   input  logic signed [ANG_W-1:0] pitch,
   input  logic [HR_W-1:0]         heart_rate,
   input  logic [HR_W-1:0]         hr_setpoint,
   input  logic                    cadence,
   input  logic                    brake,
   input  logic [1:0]              mode,
   input  logic [OUT_W-1:0]        fixed_level,
   output logic [OUT_W-1:0]        assist_out,
   output logic                    tilt_fault,
   output logic [1:0]              state
);
   localparam int RW  = 32;
   localparam int IW  = $clog2(INTEG_MAX + 1) + 1;
   localparam int CW  = $clog2(CAD_TIMEOUT + 1);
   localparam int RCW = $clog2(RECOVER_TICKS + 1);

   localparam logic signed [RW-1:0] L_OUT_MAX  = RW'((1 << OUT_W) - 1);
   localparam logic signed [RW-1:0] L_INT_MAX  = RW'(INTEG_MAX);
   localparam logic signed [RW-1:0] L_INT_MIN  = -RW'(INTEG_MAX);
   localparam logic signed [RW-1:0] L_KP       = RW'(KP);
   localparam logic signed [RW-1:0] L_KI       = RW'(KI);
   localparam logic signed [RW-1:0] L_OFFSET   = RW'(HR_OFFSET);
   localparam logic signed [RW-1:0] L_ROLL_LIM = RW'(ROLL_LIMIT);
   localparam logic signed [RW-1:0] L_ROLL_REC = RW'(ROLL_RECOVER);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ASSIST = 2'd1, S_FAULT = 2'd2} state_t;

   state_t                r_state, w_state_nxt;
   logic [OUT_W-1:0]      r_out, w_out_nxt;
   logic                  r_tilt;
   logic signed [IW-1:0]  r_integ, w_integ_nxt;
   logic [CW-1:0]         r_cad, w_cad_nxt;
   logic [RCW-1:0]        r_rec, w_rec_nxt;

   logic signed [RW-1:0]  w_roll_w, w_abs_roll, w_pitch_w, w_pterm;
   logic signed [RW-1:0]  w_err, w_isum, w_raw, w_fix_sum;
   logic signed [IW-1:0]  w_integ_cl;
   logic [OUT_W-1:0]      w_pi_tgt, w_fix_tgt, w_tgt, w_slew;
   logic [OUT_W:0]        w_step;
   logic                  w_over, w_rec_ok, w_ped, w_go, w_hold;

   // Widening before negation keeps the most negative roll code out of range rather than wrapping.
   assign w_roll_w   = RW'(roll);
   assign w_abs_roll = (w_roll_w < 0) ? -w_roll_w : w_roll_w;
   assign w_over     = w_abs_roll > L_ROLL_LIM;
   assign w_rec_ok   = w_abs_roll <= L_ROLL_REC;

   assign w_cad_nxt = cadence ? '0 :
                      (update && (r_cad != CW'(CAD_TIMEOUT))) ? r_cad + 1'b1 : r_cad;
   assign w_ped     = w_cad_nxt < CW'(CAD_TIMEOUT);
   assign w_go      = ((mode == 2'd1) || (mode == 2'd2)) && w_ped;

   assign w_pitch_w = RW'(pitch);
   assign w_pterm   = (w_pitch_w > 0) ? (w_pitch_w <<< PITCH_SHIFT) : '0;

   assign w_err      = RW'($signed({1'b0, heart_rate})) - RW'($signed({1'b0, hr_setpoint}));
   assign w_isum     = RW'(r_integ) + w_err;
   assign w_integ_cl = (w_isum > L_INT_MAX) ? IW'(INTEG_MAX) :
                       (w_isum < L_INT_MIN) ? -IW'(INTEG_MAX) : w_isum[IW-1:0];
   assign w_raw      = L_KP * w_err + L_KI * RW'(w_integ_cl) - L_OFFSET + w_pterm;
   assign w_hold     = ((w_raw > L_OUT_MAX) && (w_err > 0)) || ((w_raw < 0) && (w_err < 0));
   assign w_pi_tgt   = (w_raw < 0) ? '0 : (w_raw > L_OUT_MAX) ? '1 : w_raw[OUT_W-1:0];

   assign w_fix_sum = RW'(fixed_level) + w_pterm;
   assign w_fix_tgt = (w_fix_sum > L_OUT_MAX) ? '1 : w_fix_sum[OUT_W-1:0];
   assign w_tgt     = (mode == 2'd1) ? w_pi_tgt : w_fix_tgt;

   // Only rises are rate-limited; any drop in target is passed straight through.
   assign w_step = {1'b0, r_out} + (OUT_W+1)'(SLEW_STEP);
   assign w_slew = (w_tgt > r_out) ?
                   (({1'b0, w_tgt} < w_step) ? w_tgt : w_step[OUT_W-1:0]) : w_tgt;

   always_comb begin
      w_state_nxt = r_state;
      w_out_nxt   = r_out;
      w_integ_nxt = r_integ;
      w_rec_nxt   = r_rec;
      if (w_over) begin
         w_state_nxt = S_FAULT;
         w_out_nxt   = '0;
         w_integ_nxt = '0;
         w_rec_nxt   = '0;
      end else if (r_state == S_FAULT) begin
         w_out_nxt   = '0;
         w_integ_nxt = '0;
         if (update) begin
            if (!w_rec_ok) begin
               w_rec_nxt = '0;
            end else if (r_rec == RCW'(RECOVER_TICKS - 1)) begin
               w_state_nxt = S_IDLE;
               w_rec_nxt   = '0;
            end else begin
               w_rec_nxt = r_rec + 1'b1;
            end
         end
      end else if (brake) begin
         w_state_nxt = S_IDLE;
         w_out_nxt   = '0;
         w_integ_nxt = '0;
      end else if (update) begin
         if (w_go) begin
            w_state_nxt = S_ASSIST;
            w_out_nxt   = w_slew;
            if (mode == 2'd1)
               w_integ_nxt = w_hold ? r_integ : w_integ_cl;
            else
               w_integ_nxt = '0;
         end else begin
            w_state_nxt = S_IDLE;
            w_out_nxt   = '0;
            w_integ_nxt = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_out   <= '0;
         r_tilt  <= 1'b0;
         r_integ <= '0;
         r_cad   <= CW'(CAD_TIMEOUT);
         r_rec   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_out   <= w_out_nxt;
         r_tilt  <= (w_state_nxt == S_FAULT);
         r_integ <= w_integ_nxt;
         r_cad   <= w_cad_nxt;
         r_rec   <= w_rec_nxt;
      end
   end

   assign assist_out = r_out;
   assign tilt_fault = r_tilt;
   assign state      = r_state;
endmodule

// File: tb/tb_assistance_pi_controller.sv
// Directed and randomized bench for assistance_pi_controller against an integer behavioural model.
module tb_assistance_pi_controller;
   localparam int OUT_MAX = 8191;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              update = 1'b0;
   logic              cadence = 1'b0;
   logic              brake = 1'b0;
   logic signed [9:0] roll = '0;
   logic signed [9:0] pitch = '0;
   logic [7:0]        heart_rate = '0;
   logic [7:0]        hr_setpoint = '0;
   logic [1:0]        mode = '0;
   logic [12:0]       fixed_level = '0;
   logic [12:0]       assist_out;
   logic              tilt_fault;
   logic [1:0]        state;

   int n_tests = 0;
   int n_fail  = 0;
   int m_out, m_state, m_integ, m_cad, m_rec;

   assistance_pi_controller dut (
      .clk(clk), .reset_n(reset_n), .update(update), .roll(roll), .pitch(pitch),
      .heart_rate(heart_rate), .hr_setpoint(hr_setpoint), .cadence(cadence), .brake(brake),
      .mode(mode), .fixed_level(fixed_level), .assist_out(assist_out),
      .tilt_fault(tilt_fault), .state(state)
   );

   always #5 clk = ~clk;

   // Model state: m_state 0=IDLE 1=ASSIST 2=FAULT, advanced once per rising edge.
   task automatic model_step();
      int ar, pr, pt, cadn, err, s, raw, tgt;
      bit ped;
      if (!reset_n) begin
         m_out = 0; m_state = 0; m_integ = 0; m_cad = 16; m_rec = 0;
         return;
      end
      ar   = (int'(roll) < 0) ? -int'(roll) : int'(roll);
      pr   = int'(pitch);
      pt   = (pr > 0) ? pr * 8 : 0;
      cadn = cadence ? 0 : (update ? ((m_cad + 1 > 16) ? 16 : m_cad + 1) : m_cad);
      ped  = (cadn < 16);
      m_cad = cadn;
      if (ar > 45) begin
         m_state = 2; m_out = 0; m_integ = 0; m_rec = 0;
      end else if (m_state == 2) begin
         m_out = 0; m_integ = 0;
         if (update) begin
            if (ar <= 20) begin
               m_rec++;
               if (m_rec == 8) begin m_state = 0; m_rec = 0; end
            end else m_rec = 0;
         end
      end else if (brake) begin
         m_state = 0; m_out = 0; m_integ = 0;
      end else if (update) begin
         if ((mode == 2'd1 || mode == 2'd2) && ped) begin
            m_state = 1;
            if (mode == 2'd1) begin
               err = int'(heart_rate) - int'(hr_setpoint);
               s   = m_integ + err;
               if (s > 1023) s = 1023;
               if (s < -1023) s = -1023;
               raw = 40 * err + 2 * s - 15 + pt;
               tgt = (raw < 0) ? 0 : ((raw > OUT_MAX) ? OUT_MAX : raw);
               if (!((raw > OUT_MAX && err > 0) || (raw < 0 && err < 0))) m_integ = s;
            end else begin
               tgt = int'(fixed_level) + pt;
               if (tgt > OUT_MAX) tgt = OUT_MAX;
               m_integ = 0;
            end
            m_out = (tgt > m_out) ? ((tgt < m_out + 64) ? tgt : m_out + 64) : tgt;
         end else begin
            m_state = 0; m_out = 0; m_integ = 0;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("model_out", 32'(assist_out), 32'(m_out));
      chk("model_state", 32'(state), 32'(m_state));
      chk("model_tilt", 32'(tilt_fault), 32'(m_state == 2));
   endtask

   task automatic upd(input bit c);
      update = 1'b1; cadence = c;
      cyc();
      update = 1'b0; cadence = 1'b0;
      cyc();
   endtask

   initial begin
      // Reset with arbitrary activity on the inputs
      mode = 2'd1; update = 1'b1; cadence = 1'b1; brake = 1'b1;
      roll = 10'sd100; pitch = 10'sd50; heart_rate = 8'd200; fixed_level = 13'd999;
      repeat (3) cyc();
      reset_n = 1'b1; update = 1'b0; cadence = 1'b0; brake = 1'b0;
      roll = '0; pitch = '0; heart_rate = 8'd130; hr_setpoint = 8'd120;
      cyc();
      chk("reset_out", 32'(assist_out), 32'd0);
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_tilt", 32'(tilt_fault), 32'd0);
      for (int i = 0; i < 4; i++) begin
         upd(1'b0);
         chk("no_cadence_idle", 32'(state), 32'd0);
      end

      // Ramp: first six steps are slew-limited regardless of the integral term
      for (int i = 0; i < 6; i++) begin
         upd(i % 4 == 0);
         chk("ramp", 32'(assist_out), 32'(64 * (i + 1)));
      end
      for (int i = 6; i < 14; i++) upd(i % 4 == 0);
      pitch = 10'sd10;
      for (int i = 0; i < 6; i++) upd(i % 4 == 0);
      pitch = -10'sd10;
      for (int i = 0; i < 6; i++) upd(i % 4 == 0);
      pitch = '0;

      // Tilt fault and recovery
      roll = 10'sd46;
      cyc();
      chk("tilt_out", 32'(assist_out), 32'd0);
      chk("tilt_flag", 32'(tilt_fault), 32'd1);
      chk("tilt_state", 32'(state), 32'd2);
      roll = 10'sd20;
      for (int k = 1; k <= 8; k++) begin
         upd(k % 4 == 0);
         if (k == 7) chk("recover_wait", 32'(state), 32'd2);
      end
      chk("recover_idle", 32'(state), 32'd0);
      upd(1'b1);
      chk("recover_ramp", 32'(assist_out), 32'd64);
      roll = -10'sd46;
      cyc();
      chk("neg_tilt", 32'(state), 32'd2);
      roll = -10'sd512;
      cyc();
      chk("min_roll_tilt", 32'(tilt_fault), 32'd1);
      roll = '0;
      for (int k = 0; k < 8; k++) upd(1'b1);

      // Brake and tilt together: fault wins
      for (int k = 0; k < 3; k++) upd(1'b1);
      brake = 1'b1; roll = 10'sd50;
      cyc();
      chk("brake_tilt", 32'(state), 32'd2);
      brake = 1'b0; roll = '0;
      for (int k = 0; k < 8; k++) upd(1'b1);

      // Brake coincident with an update
      for (int k = 0; k < 3; k++) upd(1'b1);
      brake = 1'b1; update = 1'b1;
      cyc();
      chk("brake_out", 32'(assist_out), 32'd0);
      chk("brake_state", 32'(state), 32'd0);
      brake = 1'b0; update = 1'b0;
      cyc();

      // Integrator windup: err=+100 settles at 40*100 + 2*1023 - 15
      heart_rate = 8'd220; hr_setpoint = 8'd120;
      for (int k = 0; k < 130; k++) upd(k % 4 == 0);
      chk("integ_sat", 32'(assist_out), 32'd6031);
      heart_rate = 8'd255; hr_setpoint = 8'd0; pitch = 10'sd511;
      for (int k = 0; k < 40; k++) upd(k % 4 == 0);
      chk("out_sat", 32'(assist_out), 32'd8191);
      pitch = '0;

      // Cadence timeout
      heart_rate = 8'd130; hr_setpoint = 8'd120;
      upd(1'b1);
      for (int k = 0; k < 15; k++) upd(1'b0);
      chk("cad_15", 32'(state), 32'd1);
      upd(1'b0);
      chk("cad_16_state", 32'(state), 32'd0);
      chk("cad_16_out", 32'(assist_out), 32'd0);
      upd(1'b1);
      chk("cad_coincident", 32'(state), 32'd1);

      // Fixed mode
      mode = 2'd0;
      upd(1'b1);
      chk("mode_off", 32'(state), 32'd0);
      mode = 2'd2; fixed_level = 13'd200;
      for (int i = 0; i < 4; i++) begin
         upd(i == 0);
         chk("fixed_ramp", 32'(assist_out), 32'((i < 3) ? 64 * (i + 1) : 200));
      end

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         int r;
         reset_n     = ($urandom_range(0, 99) != 0);
         update      = $urandom_range(0, 1);
         cadence     = ($urandom_range(0, 3) == 0);
         brake       = ($urandom_range(0, 29) == 0);
         mode        = 2'($urandom_range(0, 3));
         heart_rate  = 8'($urandom);
         hr_setpoint = 8'($urandom);
         fixed_level = 13'($urandom);
         pitch       = 10'($urandom);
         if ($urandom_range(0, 19) == 0) r = int'($urandom_range(0, 1023)) - 512;
         else r = int'($urandom_range(0, 30)) - 15;
         roll = 10'(r);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/assistance_pi_controller.md
# assistance_pi_controller

Parametrised motor-assistance controller that converts rider heart rate, terrain pitch, bike roll, cadence and brake inputs into a slew-limited assistance demand for the current-control block. It replaces proportional-only assistance with a PI heart-rate loop that includes anti-windup, latched tilt-fault shutdown with recovery, cadence-timeout detection and selectable operating modes. It sits between the IMU/biometric front end and the motor current controller, and computes on a periodic `update` strobe.

## Interface

- `OUT_W`, 13: assistance output width (unsigned).
- `HR_W`, 8: heart-rate and set-point width (unsigned).
- `ANG_W`, 10: roll/pitch width (signed, degrees).
- `KP`, 40: proportional gain (unsigned integer).
- `KI`, 2: integral gain (unsigned integer).
- `INTEG_MAX`, 1023: integrator clamp magnitude.
- `HR_OFFSET`, 15: constant subtracted from the PI sum.
- `PITCH_SHIFT`, 3: positive pitch is multiplied by 2^PITCH_SHIFT.
- `ROLL_LIMIT`, 45: tilt-fault threshold on |roll|.
- `ROLL_RECOVER`, 20: |roll| must be at or below this value to begin recovery.
- `RECOVER_TICKS`, 8: number of consecutive qualifying updates needed to clear a fault.
- `SLEW_STEP`, 64: maximum output increase per update.
- `CAD_TIMEOUT`, 16: number of updates without a cadence pulse before the rider is treated as not pedalling.

- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, synchronous and active-low.
- `update`  in  1  one-cycle sample strobe.
- `roll`  in  ANG_W  signed roll angle.
- `pitch`  in  ANG_W  signed pitch angle.
- `heart_rate`  in  HR_W  measured heart rate.
- `hr_setpoint`  in  HR_W  user set point.
- `cadence`  in  1  one-cycle pulse per crank event.
- `brake`  in  1  brake lever, level signal.
- `mode`  in  2  0=off, 1=HR PI, 2=fixed, 3=off.
- `fixed_level`  in  OUT_W  target level in mode 2.
- `assist_out`  out  OUT_W  registered assistance demand.
- `tilt_fault`  out  1  latched tilt fault.
- `state`  out  2  0=IDLE, 1=ASSIST, 2=FAULT.

## Operation

- The clock port is `clk` and the reset port is `reset_n`. Reset is synchronous and active-low. On reset:
  - `assist_out` = 0, `tilt_fault` = 0, `state` = IDLE.
  - The integrator is cleared.
  - The cadence counter is set to CAD_TIMEOUT, so the block starts in the not-pedalling condition.
- Signals:
  - `pedalling` = cadence counter < CAD_TIMEOUT.
  - The counter clears to 0 on a `cadence` pulse. Otherwise it increments on each `update` and saturates at CAD_TIMEOUT.
  - If a cadence pulse and an update occur in the same cycle, the counter goes to 0.
- PI path, mode 1, evaluated on `update`:
  - err = heart_rate − hr_setpoint, signed, HR_W+1 bits.
  - integ_next = clamp(integ + err, ±INTEG_MAX).
  - p_term = max(pitch, 0) << PITCH_SHIFT. Negative pitch contributes 0.
  - raw = KP·err + KI·integ_next − HR_OFFSET + p_term. Use wide enough signed arithmetic that no intermediate overflows.
  - target = clamp(raw, 0, 2^OUT_W−1).
  - Anti-windup: integ is not updated when raw > 2^OUT_W−1 and err > 0, or when raw < 0 and err < 0.
- Mode 2: target = clamp(fixed_level + p_term). The integrator is held at 0.
- Modes 0 and 3: target = 0, and the integrator is cleared.
- Slew limiting, on `update`:
  - If target > assist_out, assist_out = min(target, assist_out + SLEW_STEP).
  - If target ≤ assist_out, assist_out = target immediately. Decreases are never rate-limited.
- State machine:
  - IDLE → ASSIST on an update where mode ∈ {1,2}, pedalling, !brake and !fault.
  - ASSIST → IDLE when brake=1, when pedalling=0, or when mode ∈ {0,3}. Transitions on brake are checked every cycle. The others are evaluated on update.
  - In IDLE, target = 0 and the integrator is cleared.
  - Any state → FAULT in any cycle where |roll| > ROLL_LIMIT.
  - In FAULT, `tilt_fault` = 1, the output is forced to 0 and the integrator is cleared.
  - FAULT → IDLE after RECOVER_TICKS consecutive updates with |roll| ≤ ROLL_RECOVER. Any update with |roll| > ROLL_RECOVER resets the recovery count.
- |roll| must be computed correctly for the most negative value, so −2^(ANG_W−1) counts as over the limit.

## Timing

- Brake and tilt act every cycle, not just on update. Each forces `assist_out` = 0 on the clock edge following assertion (1-cycle latency).
- The normal control path has 1-cycle latency: `assist_out` changes only on the edge after an `update` cycle. Between updates it holds its value.
- If brake and tilt occur in the same cycle, FAULT takes priority.
- If tilt occurs in the same cycle as an update, the update's result is discarded and the output goes to 0.
- After a fault clears, the output ramps up from 0 at SLEW_STEP per update. It never steps directly to the target.
- `state` and `tilt_fault` are registered and change on the same edge as `assist_out`.

## Test plan

- **Reset state:** assert reset_n=0 while applying arbitrary inputs, then release → assist_out=0, state=IDLE, tilt_fault=0. With no cadence pulse, the block remains in IDLE on every update.
- **Slew-limited ramp:** KI=0, mode=1, HR=130, SP=120, pitch=0, cadence pulse every 4 updates → assist_out sequence 64, 128, 192, 256, 320, 384, 385, then holds at 385.
- **Pitch term:** same setup with pitch=10 → target 465. With pitch=−10 → target 385.
- **Tilt fault and recovery:** while assist_out=385, set roll=46 → next cycle assist_out=0, tilt_fault=1, state=FAULT. Then hold roll=20 for 8 updates → IDLE. Output then ramps from 64 again. A roll=−46 input produces the same fault.
- **Brake mid-update and integrator windup:**
  - Brake asserted in the same cycle as update → assist_out=0 on the next edge, integrator=0.
  - Hold err=+100 with KI=2 → integrator saturates at INTEG_MAX and does not exceed it.
  - Output saturates at 8191 with no wrap-around.
- **Cadence timeout and fixed mode:**
  - Stop cadence pulses → after 16 updates, state=IDLE and output=0.
  - A cadence pulse coincident with an update keeps the rider pedalling.
  - Mode=2 with fixed_level=200 → output ramps 64, 128, 192, 200.
